// File: rtl/ibex_rf_mp_pkg.sv
// Shared types and constants for the multi-port flip-flop register file.
package ibex_rf_mp_pkg;

  localparam int NUM_READ_MAX = 4;
  localparam int PORT_AW      = 5;
  localparam int DATA_W_MAX   = 64;

  typedef struct packed {
    logic                  en;
    logic [PORT_AW-1:0]    addr;
    logic [DATA_W_MAX-1:0] data;
  } wport_t;

  function automatic int addr_width(input bit rv32e);
    return rv32e ? 4 : 5;
  endfunction

endpackage

// File: rtl/ibex_rf_scoreboard.sv
// Per-register busy bits for outstanding loads; feeds RAW-hazard flags to the read ports.
module ibex_rf_scoreboard
  import ibex_rf_mp_pkg::*;
#(
  parameter bit RV32E       = 1'b0,
  parameter int NumRead     = 2,
  parameter bit WriteBypass = 1'b0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       issue_valid,
  input  logic [PORT_AW-1:0]         issue_addr,
  input  logic                       load_we,
  input  logic [PORT_AW-1:0]         load_addr,
  input  logic [NumRead*PORT_AW-1:0] raddr,
  output logic [NumRead-1:0]         rbusy
);

  localparam int ADDR_WIDTH = addr_width(RV32E);
  localparam int NUM_WORDS  = 2 ** ADDR_WIDTH;

  logic [NUM_WORDS-1:1] busy_q;
  logic [NUM_WORDS-1:0] busy_all;

  // A new issue supersedes a same-cycle load return to the same register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      for (int i = 1; i < NUM_WORDS; i++) begin
        if (issue_valid && (issue_addr == PORT_AW'(i))) begin
          busy_q[i] <= 1'b1;
        end else if (load_we && (load_addr == PORT_AW'(i))) begin
          busy_q[i] <= 1'b0;
        end
      end
    end
  end

  assign busy_all = {busy_q, 1'b0};

  for (genvar k = 0; k < NumRead; k++) begin : g_rbusy
    logic [PORT_AW-1:0] ra;
    logic               ra_ok;
    logic               ret_now;
    assign ra      = raddr[PORT_AW*k +: PORT_AW];
    assign ra_ok   = ~(RV32E & ra[PORT_AW-1]);
    assign ret_now = WriteBypass & load_we & (load_addr == ra);
    assign rbusy[k] = ra_ok & busy_all[ra[ADDR_WIDTH-1:0]] & ~ret_now;
  end

endmodule

// File: rtl/ibex_register_file_ff_mp.sv
// Flip-flop register file with N read ports, ALU (A) and load (B) write ports,
// optional write bypass, optional R0 dummy flop and a load busy scoreboard.
module ibex_register_file_ff_mp
  import ibex_rf_mp_pkg::*;
#(
  parameter bit                   RV32E             = 1'b0,
  parameter int                   DataWidth         = 32,
  parameter int                   NumRead           = 2,
  parameter bit                   WriteBypass       = 1'b0,
  parameter bit                   DummyInstructions = 1'b0,
  parameter logic [DataWidth-1:0] WordZeroVal       = '0
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         dummy_instr_id_i,
  input  logic                         dummy_instr_wb_i,
  input  logic [NumRead*PORT_AW-1:0]   raddr_i,
  output logic [NumRead*DataWidth-1:0] rdata_o,
  output logic [NumRead-1:0]           rbusy_o,
  input  logic [PORT_AW-1:0]           waddr_a_i,
  input  logic [DataWidth-1:0]         wdata_a_i,
  input  logic                         we_a_i,
  input  logic [PORT_AW-1:0]           waddr_b_i,
  input  logic [DataWidth-1:0]         wdata_b_i,
  input  logic                         we_b_i,
  input  logic                         issue_valid_i,
  input  logic [PORT_AW-1:0]           issue_addr_i,
  output logic                         err_o
);

  localparam int ADDR_WIDTH = addr_width(RV32E);
  localparam int NUM_WORDS  = 2 ** ADDR_WIDTH;

  wport_t wr_a;
  wport_t wr_b;

  always_comb begin
    wr_a      = '0;
    wr_a.en   = we_a_i;
    wr_a.addr = waddr_a_i;
    wr_a.data = DATA_W_MAX'(wdata_a_i);
    wr_b      = '0;
    wr_b.en   = we_b_i;
    wr_b.addr = waddr_b_i;
    wr_b.data = DATA_W_MAX'(wdata_b_i);
  end

  logic unused_wdata_hi;
  assign unused_wdata_hi = ^{wr_a.data, wr_b.data};

  logic [DataWidth-1:0] rf_q [NUM_WORDS];
  logic [DataWidth-1:0] dummy_q;
  logic                 dummy_we;
  logic                 wa_ok;
  logic                 collide;
  logic                 err_q;

  // Entry 0 is never written; x0 reads are served by the R0 mux below.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        rf_q[i] <= WordZeroVal;
      end
    end else begin
      for (int i = 1; i < NUM_WORDS; i++) begin
        if (wr_b.en && (wr_b.addr == PORT_AW'(i))) begin
          rf_q[i] <= wr_b.data[DataWidth-1:0];
        end else if (wr_a.en && (wr_a.addr == PORT_AW'(i))) begin
          rf_q[i] <= wr_a.data[DataWidth-1:0];
        end
      end
    end
  end

  assign dummy_we = DummyInstructions & wr_a.en & dummy_instr_wb_i & (wr_a.addr == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dummy_q <= WordZeroVal;
    end else if (dummy_we) begin
      dummy_q <= wr_a.data[DataWidth-1:0];
    end
  end

  // Out-of-range RV32E addresses are not registers, so they cannot collide.
  assign wa_ok   = ~(RV32E & wr_a.addr[PORT_AW-1]);
  assign collide = wr_a.en & wr_b.en & (wr_a.addr == wr_b.addr) & (wr_a.addr != '0) & wa_ok;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (collide) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;

  for (genvar k = 0; k < NumRead; k++) begin : g_read
    logic [PORT_AW-1:0]   ra;
    logic                 ra_ok;
    logic                 byp_a;
    logic                 byp_b;
    logic [DataWidth-1:0] stored;

    assign ra    = raddr_i[PORT_AW*k +: PORT_AW];
    assign ra_ok = ~(RV32E & ra[PORT_AW-1]);
    assign byp_b = WriteBypass & wr_b.en & (wr_b.addr == ra) & (ra != '0) & ra_ok;
    assign byp_a = WriteBypass & wr_a.en & (wr_a.addr == ra) & (ra != '0) & ra_ok;

    always_comb begin
      stored = WordZeroVal;
      if (!ra_ok) begin
        stored = WordZeroVal;
      end else if (ra == '0) begin
        stored = (DummyInstructions && dummy_instr_id_i) ? dummy_q : WordZeroVal;
      end else begin
        stored = rf_q[ra[ADDR_WIDTH-1:0]];
      end
    end

    assign rdata_o[DataWidth*k +: DataWidth] =
      byp_b ? wr_b.data[DataWidth-1:0] :
      byp_a ? wr_a.data[DataWidth-1:0] : stored;
  end

  ibex_rf_scoreboard #(
    .RV32E       (RV32E),
    .NumRead     (NumRead),
    .WriteBypass (WriteBypass)
  ) u_scoreboard (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .issue_valid (issue_valid_i),
    .issue_addr  (issue_addr_i),
    .load_we     (wr_b.en),
    .load_addr   (wr_b.addr),
    .raddr       (raddr_i),
    .rbusy       (rbusy_o)
  );

endmodule

// File: tb/tb_ibex_register_file_ff_mp.sv
// Bench for ibex_register_file_ff_mp: a plain RV32I instance and an RV32E/bypass/dummy
// instance share one stimulus stream and are checked against an array model.
module tb_ibex_register_file_ff_mp;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        dummy_id, dummy_wb;
  logic [9:0]  raddr;
  logic [4:0]  wa_addr, wb_addr, iss_addr;
  logic [31:0] wa_data, wb_data;
  logic        we_a, we_b, iss_v;

  logic [63:0] rdata [2];
  logic [1:0]  rbusy [2];
  logic        err   [2];

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  ibex_register_file_ff_mp #(
    .RV32E(1'b0), .DataWidth(32), .NumRead(2), .WriteBypass(1'b0), .DummyInstructions(1'b0)
  ) u0 (
    .clk_i(clk), .rst_ni(rst_n), .dummy_instr_id_i(dummy_id), .dummy_instr_wb_i(dummy_wb),
    .raddr_i(raddr), .rdata_o(rdata[0]), .rbusy_o(rbusy[0]),
    .waddr_a_i(wa_addr), .wdata_a_i(wa_data), .we_a_i(we_a),
    .waddr_b_i(wb_addr), .wdata_b_i(wb_data), .we_b_i(we_b),
    .issue_valid_i(iss_v), .issue_addr_i(iss_addr), .err_o(err[0])
  );

  ibex_register_file_ff_mp #(
    .RV32E(1'b1), .DataWidth(32), .NumRead(2), .WriteBypass(1'b1), .DummyInstructions(1'b1)
  ) u1 (
    .clk_i(clk), .rst_ni(rst_n), .dummy_instr_id_i(dummy_id), .dummy_instr_wb_i(dummy_wb),
    .raddr_i(raddr), .rdata_o(rdata[1]), .rbusy_o(rbusy[1]),
    .waddr_a_i(wa_addr), .wdata_a_i(wa_data), .we_a_i(we_a),
    .waddr_b_i(wb_addr), .wdata_b_i(wb_data), .we_b_i(we_b),
    .issue_valid_i(iss_v), .issue_addr_i(iss_addr), .err_o(err[1])
  );

  // Model: instance 1 is RV32E with bypass and dummy flop, instance 0 has none of those.
  logic [31:0] m_rf    [2][32];
  logic [31:0] m_dummy [2];
  bit          m_busy  [2][32];
  bit          m_err   [2];

  function automatic bit m_ok(int c, logic [4:0] a);
    return !(c == 1 && a >= 5'd16);
  endfunction

  function automatic logic [31:0] m_read(int c, logic [4:0] a);
    if (!m_ok(c, a)) return 32'h0;
    if (a == 5'd0) return (c == 1 && dummy_id) ? m_dummy[c] : 32'h0;
    if (c == 1 && we_b && wb_addr == a) return wb_data;
    if (c == 1 && we_a && wa_addr == a) return wa_data;
    return m_rf[c][a];
  endfunction

  function automatic bit m_rbusy(int c, logic [4:0] a);
    if (!m_ok(c, a) || a == 5'd0) return 1'b0;
    return m_busy[c][a] && !(c == 1 && we_b && wb_addr == a);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        for (int r = 0; r < 32; r++) begin
          m_rf[c][r]   <= 32'h0;
          m_busy[c][r] <= 1'b0;
        end
        m_dummy[c] <= 32'h0;
        m_err[c]   <= 1'b0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (we_a && wa_addr != 0 && m_ok(c, wa_addr)) m_rf[c][wa_addr] <= wa_data;
        if (we_b && wb_addr != 0 && m_ok(c, wb_addr)) m_rf[c][wb_addr] <= wb_data;
        if (c == 1 && we_a && dummy_wb && wa_addr == 0) m_dummy[c] <= wa_data;
        if (we_a && we_b && wa_addr == wb_addr && wa_addr != 0 && m_ok(c, wa_addr))
          m_err[c] <= 1'b1;
        if (we_b && wb_addr != 0 && m_ok(c, wb_addr)) m_busy[c][wb_addr] <= 1'b0;
        if (iss_v && iss_addr != 0 && m_ok(c, iss_addr)) m_busy[c][iss_addr] <= 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd(int c, int k);
    return rdata[c][32*k +: 32];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int c = 0; c < 2; c++) begin
        for (int k = 0; k < 2; k++) begin
          chk($sformatf("u%0d_rdata%0d", c, k), rd(c, k), m_read(c, raddr[5*k +: 5]));
          chk($sformatf("u%0d_rbusy%0d", c, k), 32'(rbusy[c][k]), 32'(m_rbusy(c, raddr[5*k +: 5])));
        end
        chk($sformatf("u%0d_err", c), 32'(err[c]), 32'(m_err[c]));
      end
    end
  end

  task automatic idle();
    dummy_id = 0; dummy_wb = 0; raddr = '0;
    wa_addr = 0; wa_data = 0; we_a = 0;
    wb_addr = 0; wb_data = 0; we_b = 0;
    iss_v = 0; iss_addr = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    #2;
    chk("rst_err0", 32'(err[0]), 0);
    chk("rst_err1", 32'(err[1]), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Sweep all addresses on both ports after reset.
    for (int i = 0; i < 32; i++) begin
      raddr = {5'(31 - i), 5'(i)};
      #2;
      chk("sweep_u0", rd(0, 0), 32'h0);
      chk("sweep_busy_u1", 32'(rbusy[1]), 0);
      cyc();
    end

    // x5 write: same-cycle read only sees it through the bypass.
    idle(); we_a = 1; wa_addr = 5; wa_data = 32'hDEADBEEF; raddr = {5'd0, 5'd5};
    #2;
    chk("x5_same_nobyp", rd(0, 0), 32'h0);
    chk("x5_same_byp", rd(1, 0), 32'hDEADBEEF);
    cyc();
    idle(); raddr = {5'd0, 5'd5};
    #2;
    chk("x5_next_u0", rd(0, 0), 32'hDEADBEEF);
    chk("x5_next_u1", rd(1, 0), 32'hDEADBEEF);
    cyc();

    // Collision on x0 is harmless.
    idle(); we_a = 1; we_b = 1; wa_addr = 0; wb_addr = 0; wa_data = 32'h1111; wb_data = 32'h2222;
    cyc();
    idle();
    #2;
    chk("x0_coll_err0", 32'(err[0]), 0);
    chk("x0_coll_err1", 32'(err[1]), 0);
    chk("x0_coll_rd0", rd(0, 0), 32'h0);
    chk("x0_coll_rd1", rd(1, 0), 32'h0);
    cyc();

    // Collision on x7: port B wins, err sticks.
    idle(); we_a = 1; we_b = 1; wa_addr = 7; wb_addr = 7; wa_data = 32'h1111; wb_data = 32'h2222;
    raddr = {5'd0, 5'd7};
    #2;
    chk("x7_byp", rd(1, 0), 32'h2222);
    chk("x7_err_pre", 32'(err[0]), 0);
    cyc();
    idle(); raddr = {5'd0, 5'd7};
    #2;
    chk("x7_u0", rd(0, 0), 32'h2222);
    chk("x7_u1", rd(1, 0), 32'h2222);
    chk("x7_err0", 32'(err[0]), 1);
    chk("x7_err1", 32'(err[1]), 1);
    cyc();

    // Busy scoreboard on x9.
    idle(); iss_v = 1; iss_addr = 9; raddr = {5'd9, 5'd0};
    #2;
    chk("x9_busy_pre", 32'(rbusy[0][1]), 0);
    cyc();
    idle(); we_a = 1; wa_addr = 9; wa_data = 32'hA5; raddr = {5'd9, 5'd0};
    #2;
    chk("x9_busy_u0", 32'(rbusy[0][1]), 1);
    chk("x9_busy_u1", 32'(rbusy[1][1]), 1);
    cyc();
    idle(); we_b = 1; wb_addr = 9; wb_data = 32'h55; raddr = {5'd9, 5'd0};
    #2;
    chk("x9_porta_keeps_busy", 32'(rbusy[0][1]), 1);
    chk("x9_ret_byp_busy", 32'(rbusy[1][1]), 0);
    chk("x9_ret_byp_data", rd(1, 1), 32'h55);
    chk("x9_ret_nobyp_data", rd(0, 1), 32'hA5);
    cyc();
    idle(); raddr = {5'd9, 5'd0};
    #2;
    chk("x9_clear_u0", 32'(rbusy[0][1]), 0);
    chk("x9_data_u0", rd(0, 1), 32'h55);
    cyc();
    idle(); iss_v = 1; iss_addr = 9; we_b = 1; wb_addr = 9; wb_data = 32'h66; raddr = {5'd9, 5'd0};
    cyc();
    idle(); raddr = {5'd9, 5'd0};
    #2;
    chk("x9_set_wins_u0", 32'(rbusy[0][1]), 1);
    chk("x9_set_wins_u1", 32'(rbusy[1][1]), 1);
    chk("x9_data66", rd(0, 1), 32'h66);
    cyc();

    // Asynchronous reset in mid-cycle.
    idle(); we_a = 1; wa_addr = 3; wa_data = 32'hABCD; iss_v = 1; iss_addr = 4;
    cyc();
    idle(); raddr = {5'd4, 5'd3};
    #2;
    chk("x3_pre_rst", rd(0, 0), 32'hABCD);
    chk("x4_busy_pre_rst", 32'(rbusy[1][1]), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("x3_rst_u0", rd(0, 0), 32'h0);
    chk("x3_rst_u1", rd(1, 0), 32'h0);
    chk("x4_rst_busy", 32'(rbusy[0][1]), 0);
    chk("rst_err_clr0", 32'(err[0]), 0);
    chk("rst_err_clr1", 32'(err[1]), 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // RV32E drops x20 on u1 only.
    idle(); we_a = 1; wa_addr = 20; wa_data = 32'h1234; iss_v = 1; iss_addr = 20;
    cyc();
    idle(); raddr = {5'd20, 5'd20};
    #2;
    chk("x20_u0", rd(0, 0), 32'h1234);
    chk("x20_u1", rd(1, 0), 32'h0);
    chk("x20_busy_u0", 32'(rbusy[0][1]), 1);
    chk("x20_busy_u1", 32'(rbusy[1][1]), 0);
    cyc();

    // Dummy write to R0.
    idle(); we_a = 1; wa_addr = 0; wa_data = 32'h77; dummy_wb = 1;
    cyc();
    idle(); dummy_id = 1;
    #2;
    chk("dummy_u1", rd(1, 0), 32'h77);
    chk("dummy_u0", rd(0, 0), 32'h0);
    cyc();
    idle();
    #2;
    chk("dummy_off_u1", rd(1, 0), 32'h0);
    cyc();

    // Mixed traffic over a narrow address range so collisions and hazards recur.
    for (int i = 0; i < 60; i++) begin
      we_a     = 1'($urandom_range(0, 1));
      we_b     = 1'($urandom_range(0, 1));
      wa_addr  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(14, 18)) : 5'($urandom_range(0, 7));
      wb_addr  = 5'($urandom_range(0, 7));
      wa_data  = $urandom;
      wb_data  = $urandom;
      iss_v    = 1'($urandom_range(0, 1));
      iss_addr = 5'($urandom_range(0, 7));
      dummy_wb = 1'($urandom_range(0, 1));
      dummy_id = 1'($urandom_range(0, 1));
      raddr    = {5'($urandom_range(0, 17)), 5'($urandom_range(0, 7))};
      cyc();
    end

    idle();
    cyc();
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
